// File: rtl/arvi_pkg.sv
// Shared ARVI types and constants: fetch FSM states, IF/ID source select, NOP encoding.
`include "arvi_defines.svh"

package arvi_pkg;

   localparam int               XLEN     = `XLEN;
   localparam logic [31:0]      NOP_INST = 32'h0000_0013;
   localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);

   typedef enum logic [1:0] {FETCH, DRAIN, SKID, ERR} if_state_t;

   typedef enum logic [2:0] {
      SRC_HOLD, SRC_BUBBLE, SRC_MEM, SRC_SKID, SRC_ERR
   } ifid_src_t;

   typedef struct packed {
      logic [31:0]     inst;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/arvi_defines.svh
// Global width defines shared by the ARVI datapath.
`ifndef ARVI_DEFINES_SVH
`define ARVI_DEFINES_SVH
`define XLEN 32
`endif

// File: rtl/pc_gen.sv
// Next-PC candidates: sequential pc+4 and the redirect target (trap wins over branch),
// plus the misaligned-target flag.
`include "arvi_defines.svh"

module pc_gen
   import arvi_pkg::*;
(
   input  logic [`XLEN-1:0] pc,
   input  logic             trap,
   input  logic [`XLEN-1:0] trap_pc,
   input  logic             redirect,
   input  logic [`XLEN-1:0] redirect_pc,
   output logic [`XLEN-1:0] pc_inc,
   output logic [`XLEN-1:0] target,
   output logic             target_valid,
   output logic             target_misaligned
);

   assign pc_inc            = pc + PC_STEP;
   assign target            = trap ? trap_pc : redirect_pc;
   assign target_valid      = trap | redirect;
   assign target_misaligned = is_misaligned(target);

endmodule

// File: rtl/if_stage.sv
// ARVI instruction fetch: PC, single-outstanding memory request, skid buffer for
// decode back-pressure, redirect draining and misaligned-target exception entries.
`include "arvi_defines.svh"

module if_stage
   import arvi_pkg::*;
#(
   parameter logic [`XLEN-1:0] RESET_VECTOR = 'h8000_0000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   output logic             o_req,
   output logic [`XLEN-1:0] o_addr,
   input  logic             i_ack,
   input  logic [31:0]      i_data,
   input  logic             i_stall,
   input  logic             i_redirect,
   input  logic [`XLEN-1:0] i_redirect_pc,
   input  logic             i_trap,
   input  logic [`XLEN-1:0] i_trap_pc,
   output logic [31:0]      o_inst,
   output logic [`XLEN-1:0] o_pc,
   output logic             o_valid,
   output logic             o_ex_inst_misaligned
);

   if_state_t        state, state_n;
   logic [XLEN-1:0]  pc, pc_n;
   logic [XLEN-1:0]  drain_pc, drain_pc_n;
   logic [XLEN-1:0]  resume_pc;
   fetch_entry_t     skid, skid_n;
   logic             skid_valid, skid_valid_n;
   logic             err_pend, err_pend_n;
   logic             started;
   ifid_src_t        ifid_src;
   logic             ack;

   logic [XLEN-1:0]  pc_inc, tgt;
   logic             tgt_valid, tgt_mis;

   pc_gen u_pc_gen (
      .pc                (pc),
      .trap              (i_trap),
      .trap_pc           (i_trap_pc),
      .redirect          (i_redirect),
      .redirect_pc       (i_redirect_pc),
      .pc_inc            (pc_inc),
      .target            (tgt),
      .target_valid      (tgt_valid),
      .target_misaligned (tgt_mis)
   );

   // started keeps o_req low for the first cycle after reset releases.
   assign o_req  = started & ((state == FETCH) | (state == DRAIN));
   assign o_addr = pc;
   assign ack    = i_ack & o_req;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_n      = state;
      pc_n         = pc;
      drain_pc_n   = drain_pc;
      skid_n       = skid;
      skid_valid_n = skid_valid;
      err_pend_n   = err_pend;
      ifid_src     = i_stall ? SRC_HOLD : SRC_BUBBLE;
      resume_pc    = drain_pc;

      case (state)
         FETCH: begin
            if (tgt_valid) begin
               if (ack) begin
                  pc_n = tgt;
                  if (tgt_mis) begin
                     state_n    = ERR;
                     err_pend_n = 1'b1;
                  end
               end else begin
                  drain_pc_n = tgt;
                  state_n    = DRAIN;
               end
            end else if (ack) begin
               pc_n = pc_inc;
               if (i_stall) begin
                  skid_n       = '{inst: i_data, pc: pc};
                  skid_valid_n = 1'b1;
                  state_n      = SKID;
               end else begin
                  ifid_src = SRC_MEM;
               end
            end
         end
         DRAIN: begin
            // The newest redirect wins over the latched one, even in the ack cycle.
            resume_pc  = tgt_valid ? tgt : drain_pc;
            drain_pc_n = resume_pc;
            if (ack) begin
               pc_n = resume_pc;
               if (is_misaligned(resume_pc)) begin
                  state_n    = ERR;
                  err_pend_n = 1'b1;
               end else begin
                  state_n = FETCH;
               end
            end
         end
         SKID: begin
            if (tgt_valid) begin
               skid_valid_n = 1'b0;
               pc_n         = tgt;
               if (tgt_mis) begin
                  state_n    = ERR;
                  err_pend_n = 1'b1;
               end else begin
                  state_n = FETCH;
               end
            end else if (!i_stall) begin
               ifid_src     = SRC_SKID;
               skid_valid_n = 1'b0;
               state_n      = FETCH;
            end
         end
         ERR: begin
            if (tgt_valid && !tgt_mis) begin
               pc_n       = tgt;
               err_pend_n = 1'b0;
               state_n    = FETCH;
            end else if (i_trap && tgt_mis) begin
               pc_n       = tgt;
               err_pend_n = 1'b1;
            end
         end
         default: state_n = FETCH;
      endcase

      // The exception entry is published as soon as decode can take it.
      if (err_pend_n && !i_stall) begin
         ifid_src   = SRC_ERR;
         err_pend_n = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state                <= FETCH;
         pc                   <= RESET_VECTOR;
         drain_pc             <= RESET_VECTOR;
         skid_valid           <= 1'b0;
         err_pend             <= 1'b0;
         started              <= 1'b0;
         o_inst               <= NOP_INST;
         o_pc                 <= RESET_VECTOR;
         o_valid              <= 1'b0;
         o_ex_inst_misaligned <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         drain_pc   <= drain_pc_n;
         skid_valid <= skid_valid_n;
         err_pend   <= err_pend_n;
         started    <= 1'b1;
         case (ifid_src)
            SRC_BUBBLE: begin
               o_inst               <= NOP_INST;
               o_valid              <= 1'b0;
               o_ex_inst_misaligned <= 1'b0;
            end
            SRC_MEM: begin
               o_inst               <= i_data;
               o_pc                 <= pc;
               o_valid              <= 1'b1;
               o_ex_inst_misaligned <= 1'b0;
            end
            SRC_SKID: begin
               o_inst               <= skid.inst;
               o_pc                 <= skid.pc;
               o_valid              <= skid_valid;
               o_ex_inst_misaligned <= 1'b0;
            end
            SRC_ERR: begin
               o_inst               <= NOP_INST;
               o_pc                 <= pc_n;
               o_valid              <= 1'b1;
               o_ex_inst_misaligned <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: the skid payload has no reset; skid_valid alone says whether it means anything.
   always_ff @(posedge i_clk) begin
      skid <= skid_n;
   end

endmodule
